fifo_arbiter_ctrl: RTL and testbench
====================================

Name: fifo_arbiter_ctrl

Overview:
- Controller that shares one synchronous FIFO between two producers and drains it into a single ready/valid consumer, e.g. a UART transmitter.
- Write side: round-robin arbiter feeding the FIFO write port.
- Read side: FSM that sequences FIFO reads (registered dout, 1-cycle read latency) and presents each word on a ready/valid output.
- Instantiated beside the FIFO; drives the FIFO's wr_en/din/rd_en and observes its full/empty/dout.

Parameters:
WIDTH, 8, data word width; must match the FIFO's WIDTH.
CNT_WIDTH, 16, width of the drained-word counter.

Ports:
clk  input  1  system clock; all state on rising edge
rst  input  1  asynchronous, active-high reset
a_valid  input  1  requester A has a word
a_data  input  WIDTH  requester A word
a_ready  output  1  A's word accepted this cycle when a_valid & a_ready
b_valid  input  1  requester B has a word
b_data  input  WIDTH  requester B word
b_ready  output  1  B's word accepted this cycle when b_valid & b_ready
fifo_wr_en  output  1  to FIFO wr_en
fifo_din  output  WIDTH  to FIFO din
fifo_full  input  1  from FIFO full
fifo_rd_en  output  1  to FIFO rd_en
fifo_dout  input  WIDTH  from FIFO dout; valid the cycle after rd_en
fifo_empty  input  1  from FIFO empty
drain_en  input  1  read side may start new FIFO reads only while high
out_valid  output  1  out_data holds a word
out_data  output  WIDTH  word to consumer
out_ready  input  1  consumer accepts when out_valid & out_ready
drained_cnt  output  CNT_WIDTH  words handed to consumer; wraps modulo 2^CNT_WIDTH

Behaviour:
- Reset (async, immediate): read FSM -> IDLE; out_valid=0; out_data=0; drained_cnt=0; priority pointer -> A; fifo_rd_en=0.
- Reset mid-transfer drops any fetched or held word. Writes in flight are not undone; the FIFO is reset by the same rst.
- Write arbiter (combinational grant, registered priority):
  - No grants when fifo_full=1: a_ready=b_ready=0.
  - Otherwise, if only one requester is valid, it is granted.
  - If both are valid, the one named by the priority pointer is granted.
  - At most one grant per cycle. Only the granted requester's ready is 1; the other's ready is 0 even if valid.
  - fifo_wr_en = (a_valid&a_ready)|(b_valid&b_ready); fifo_din = granted data, else 0.
  - After each accepted word, the pointer moves to the other requester. With no acceptance, the pointer holds.
  - Ready must not depend on the read side in the same cycle.
- Read FSM, states IDLE, FETCH, HOLD:
  - IDLE: if drain_en & !fifo_empty -> fifo_rd_en=1 this cycle, go FETCH.
  - FETCH: fifo_dout is valid. Register it into out_data, set out_valid=1, go HOLD. fifo_rd_en=0.
  - HOLD: out_valid=1, out_data stable until handshake.
    - On out_ready: drained_cnt+1.
    - If drain_en & !fifo_empty in the same cycle: assert fifo_rd_en, out_valid->0 next cycle, go FETCH.
    - Else go IDLE with out_valid->0.
    - Without out_ready: stay in HOLD.
  - fifo_rd_en is only ever asserted when fifo_empty=0, so the FIFO never sees a read while empty.
  - Latency: a word written at edge N (empty drops after N) is earliest at out_valid at edge N+2. Peak drain rate is 1 word per 2 cycles.
- Simultaneous write and read in one cycle are legal and passed straight to the FIFO.
- drain_en low: finishes the current FETCH/HOLD word, then starts no new reads.
- drained_cnt wraps from all-ones to 0 without flag.

Test Plan:
- Reset mid-HOLD with out_data=0x5A, then deassert -> out_valid=0, out_data=0, drained_cnt=0, FSM IDLE; a_valid=1, a_data=0x11 is accepted in the first cycle after reset.
- Only A valid, 3 words 0x01,0x02,0x03, out_ready=1, drain_en=1 -> a_ready=1 each cycle; consumer receives 0x01,0x02,0x03 in order; drained_cnt=3.
- A and B valid continuously (A=0xA0.., B=0xB0..) for 8 cycles, FIFO never full -> grants alternate A,B,A,B...; 4 words each accepted in that order.
- Fill FIFO until fifo_full=1 with out_ready=0 -> a_ready=b_ready=0 and fifo_wr_en=0 while full; one out_ready pulse frees a slot; the next grant goes to the requester the pointer names.
- out_ready held low 5 cycles in HOLD with out_data=0x3C -> out_valid=1 and out_data=0x3C stable all 5 cycles; fifo_rd_en=0; drained_cnt unchanged until out_ready=1.
- drain_en=0 with FIFO holding 2 words -> fifo_rd_en never asserts; raising drain_en drains both; preload drained_cnt near 0xFFFF by 65535 transfers -> it wraps to 0x0000.

Source files
------------

// File: rtl/fifo_arbiter_ctrl.sv
// Shares one synchronous FIFO between two round-robin producers and drains
// it into a single ready/valid consumer through a fetch/hold read sequencer.
module fifo_arbiter_ctrl #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 a_valid,
  input  logic [WIDTH-1:0]     a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [WIDTH-1:0]     b_data,
  output logic                 b_ready,
  output logic                 fifo_wr_en,
  output logic [WIDTH-1:0]     fifo_din,
  input  logic                 fifo_full,
  output logic                 fifo_rd_en,
  input  logic [WIDTH-1:0]     fifo_dout,
  input  logic                 fifo_empty,
  input  logic                 drain_en,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] drained_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_t;

  state_t               state_q, state_d;
  logic                 out_valid_q, out_valid_d;
  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 prio_q, prio_d;
  logic                 gnt_a, gnt_b;
  logic                 can_read;
  logic                 rd_en;

  // prio_q: 0 names A, 1 names B; only consulted when both are valid
  always_comb begin
    gnt_a  = !fifo_full && a_valid && (!b_valid || !prio_q);
    gnt_b  = !fifo_full && b_valid && (!a_valid || prio_q);
    prio_d = prio_q;
    if (gnt_a) begin
      prio_d = 1'b1;
    end else if (gnt_b) begin
      prio_d = 1'b0;
    end
  end

  assign a_ready    = gnt_a;
  assign b_ready    = gnt_b;
  assign fifo_wr_en = gnt_a | gnt_b;
  assign fifo_din   = gnt_a ? a_data :
                      gnt_b ? b_data : '0;

  always_comb begin
    can_read    = drain_en && !fifo_empty;
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    cnt_d       = cnt_q;
    rd_en       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (can_read) begin
          rd_en   = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        out_data_d  = fifo_dout;
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      HOLD: begin
        if (out_ready) begin
          cnt_d       = cnt_q + CNT_WIDTH'(1);
          out_valid_d = 1'b0;
          if (can_read) begin
            rd_en   = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // keep the read strobe quiet while reset is asserted
  assign fifo_rd_en  = rd_en && !rst;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign drained_cnt = cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      cnt_q       <= '0;
      prio_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      cnt_q       <= cnt_d;
      prio_q      <= prio_d;
    end
  end

endmodule

// File: tb/tb_fifo_arbiter_ctrl.sv
// Bench for fifo_arbiter_ctrl: behavioural FIFO, arbitration/ordering
// reference model, vector table and directed corner-case sequences.
module tb_fifo_arbiter_ctrl;

  localparam int W     = 8;
  localparam int CW    = 8;
  localparam int DEPTH = 8;

  logic          clk;
  logic          rst;
  logic          a_valid, b_valid;
  logic [W-1:0]  a_data, b_data;
  logic          a_ready, b_ready;
  logic          fifo_wr_en, fifo_rd_en;
  logic [W-1:0]  fifo_din, fifo_dout;
  logic          fifo_full, fifo_empty;
  logic          drain_en;
  logic          out_valid, out_ready;
  logic [W-1:0]  out_data;
  logic [CW-1:0] drained_cnt;

  fifo_arbiter_ctrl #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_full(fifo_full),
    .fifo_rd_en(fifo_rd_en), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .drain_en(drain_en),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .drained_cnt(drained_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural synchronous FIFO with registered dout
  logic [W-1:0] mem [DEPTH];
  int f_wp, f_rp, f_cnt;
  assign fifo_full  = (f_cnt == DEPTH);
  assign fifo_empty = (f_cnt == 0);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      f_wp <= 0; f_rp <= 0; f_cnt <= 0; fifo_dout <= '0;
    end else begin
      if (fifo_wr_en && !fifo_full) begin
        mem[f_wp] <= fifo_din;
        f_wp <= (f_wp + 1) % DEPTH;
      end
      if (fifo_rd_en && !fifo_empty) begin
        fifo_dout <= mem[f_rp];
        f_rp <= (f_rp + 1) % DEPTH;
      end
      f_cnt <= f_cnt + ((fifo_wr_en && !fifo_full) ? 1 : 0)
                     - ((fifo_rd_en && !fifo_empty) ? 1 : 0);
    end
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s: got timeout/unexpected expected normal progress", nm);
  endtask

  // Reference model: whose turn it is, words in flight, words delivered
  logic [W-1:0]  exp_q[$];
  logic [W-1:0]  rx_q[$];
  logic [W-1:0]  want_q[$];
  logic          m_turn_b;
  logic [CW-1:0] m_cnt;
  logic          hold_prev;
  logic [W-1:0]  hold_data;
  logic          win_a, win_b;
  logic [W-1:0]  win_d, got_w;

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_turn_b  = 1'b0;
      m_cnt     = '0;
      hold_prev = 1'b0;
    end else begin
      win_a = 1'b0;
      win_b = 1'b0;
      if (!fifo_full) begin
        if (a_valid && b_valid) begin
          if (m_turn_b) win_b = 1'b1;
          else win_a = 1'b1;
        end else if (a_valid) begin
          win_a = 1'b1;
        end else if (b_valid) begin
          win_b = 1'b1;
        end
      end
      win_d = win_a ? a_data : (win_b ? b_data : '0);
      chk("a_ready", a_ready, win_a);
      chk("b_ready", b_ready, win_b);
      chk("wr_en", fifo_wr_en, win_a | win_b);
      chk("din", fifo_din, win_d);
      chk("rd_while_empty", fifo_rd_en & fifo_empty, 0);
      chk("drained_cnt", drained_cnt, m_cnt);
      if (hold_prev) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, hold_data);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("out_unexpected_word");
        end else begin
          got_w = exp_q.pop_front();
          chk("out_order", out_data, got_w);
        end
        rx_q.push_back(out_data);
        m_cnt = m_cnt + 1'b1;
      end
      hold_prev = out_valid && !out_ready;
      hold_data = out_data;
      if (win_a || win_b) begin
        exp_q.push_back(win_d);
        m_turn_b = win_a;
      end
    end
  end

  task automatic idle_inputs();
    a_valid = 0; b_valid = 0; a_data = '0; b_data = '0;
  endtask

  task automatic wait_drain(input int maxc);
    bit done = 0;
    @(posedge clk); #1;
    idle_inputs();
    drain_en = 1; out_ready = 1;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !out_valid) begin
        done = 1;
        break;
      end
    end
    if (!done) fail_now("drain_timeout");
  endtask

  task automatic wait_valid(input int maxc);
    bit done = 0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (out_valid) begin
        done = 1;
        break;
      end
    end
    if (!done) fail_now("valid_timeout");
  endtask

  task automatic chk_rx(input string nm);
    chk({nm, "_count"}, rx_q.size(), want_q.size());
    for (int i = 0; i < want_q.size() && i < rx_q.size(); i++)
      chk(nm, rx_q[i], want_q[i]);
  endtask

  typedef struct {
    logic av;
    logic bv;
    logic ar;
    logic br;
  } vec_t;

  vec_t          tbl[8];
  logic [W-1:0]  ed;
  logic [CW-1:0] base;
  logic          exp_b;
  bit            got;
  int            n_acc;

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1, 1, 1, 0};
    tbl[1] = '{1, 1, 0, 1};
    tbl[2] = '{0, 1, 0, 1};
    tbl[3] = '{1, 1, 1, 0};
    tbl[4] = '{0, 0, 0, 0};
    tbl[5] = '{1, 1, 0, 1};
    tbl[6] = '{1, 0, 1, 0};
    tbl[7] = '{1, 1, 0, 1};

    rst = 1; idle_inputs(); drain_en = 0; out_ready = 0;
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_cnt", drained_cnt, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    #10 rst = 0;

    // Arbitration table, FIFO not draining
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      a_valid = tbl[i].av; b_valid = tbl[i].bv;
      a_data = 8'hA0 + 8'(i); b_data = 8'hB0 + 8'(i);
      ed = tbl[i].ar ? a_data : (tbl[i].br ? b_data : 8'h00);
      @(negedge clk);
      chk("tbl_a_ready", a_ready, tbl[i].ar);
      chk("tbl_b_ready", b_ready, tbl[i].br);
      chk("tbl_din", fifo_din, ed);
      chk("tbl_rd_en", fifo_rd_en, 0);
    end
    rx_q.delete();
    wait_drain(100);
    want_q = '{8'hA0, 8'hB1, 8'hB2, 8'hA3, 8'hB5, 8'hA6, 8'hB7};
    chk_rx("tbl_rx");

    // Only A valid, three words
    rx_q.delete(); base = m_cnt;
    for (int i = 1; i <= 3; i++) begin
      @(posedge clk); #1;
      a_valid = 1; a_data = 8'(i);
      @(negedge clk);
      chk("onlya_ready", a_ready, 1);
    end
    wait_drain(50);
    want_q = '{8'h01, 8'h02, 8'h03};
    chk_rx("onlya_rx");
    chk("onlya_cnt", drained_cnt, base + 8'd3);

    // Consumer stall in HOLD
    @(posedge clk); #1;
    out_ready = 0; a_valid = 1; a_data = 8'h3C;
    @(posedge clk); #1;
    a_data = 8'h3D;
    @(posedge clk); #1;
    a_valid = 0;
    wait_valid(20);
    base = m_cnt;
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_data", out_data, 8'h3C);
      chk("stall_rd_en", fifo_rd_en, 0);
      chk("stall_cnt", drained_cnt, base);
      @(negedge clk);
    end
    wait_drain(50);

    // drain_en low with two words queued
    rx_q.delete();
    @(posedge clk); #1;
    drain_en = 0; a_valid = 1; a_data = 8'h21;
    @(posedge clk); #1;
    a_data = 8'h22;
    @(posedge clk); #1;
    a_valid = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("nodrain_rd_en", fifo_rd_en, 0);
      chk("nodrain_valid", out_valid, 0);
    end
    wait_drain(50);
    want_q = '{8'h21, 8'h22};
    chk_rx("nodrain_rx");

    // Fill to full, then free one slot
    got = 0;
    @(posedge clk); #1;
    drain_en = 1; out_ready = 0; a_valid = 1; b_valid = 1;
    for (int i = 0; i < 40; i++) begin
      a_data = 8'hC0 + 8'(i); b_data = 8'hD0 + 8'(i);
      @(negedge clk);
      if (fifo_full) begin
        got = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) fail_now("fill_timeout");
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("full_a_ready", a_ready, 0);
      chk("full_b_ready", b_ready, 0);
      chk("full_wr_en", fifo_wr_en, 0);
    end
    @(posedge clk); #1;
    out_ready = 1;
    @(negedge clk);
    chk("free_rd_en", fifo_rd_en, 1);
    @(posedge clk); #1;
    out_ready = 0;
    exp_b = m_turn_b;
    @(negedge clk);
    chk("free_a_ready", a_ready, !exp_b);
    chk("free_b_ready", b_ready, exp_b);
    wait_drain(100);

    // Randomised traffic against the reference model
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      a_valid = 1'($urandom); b_valid = 1'($urandom);
      a_data = 8'($urandom); b_data = 8'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      drain_en = ($urandom_range(0, 9) < 8);
    end
    wait_drain(200);

    // Reset while a word is held
    rx_q.delete();
    @(posedge clk); #1;
    out_ready = 0; a_valid = 1; a_data = 8'h5A;
    @(posedge clk); #1;
    a_valid = 0;
    wait_valid(20);
    chk("prerst_data", out_data, 8'h5A);
    @(posedge clk); #2;
    rst = 1;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_data", out_data, 0);
    chk("midrst_cnt", drained_cnt, 0);
    chk("midrst_rd_en", fifo_rd_en, 0);
    @(posedge clk); #1;
    rst = 0; a_valid = 1; a_data = 8'h11; out_ready = 1;
    @(negedge clk);
    chk("postrst_a_ready", a_ready, 1);
    chk("postrst_din", fifo_din, 8'h11);
    wait_drain(50);
    want_q = '{8'h11};
    chk_rx("postrst_rx");

    // Counter wrap: 1 already drained, 254 more reach all-ones
    n_acc = 0;
    for (int i = 0; i < 2000 && n_acc < 254; i++) begin
      @(posedge clk); #1;
      a_valid = 1; a_data = 8'(n_acc);
      @(negedge clk);
      if (a_ready) n_acc++;
    end
    wait_drain(100);
    chk("wrap_allones", drained_cnt, 8'hFF);
    @(posedge clk); #1;
    a_valid = 1; a_data = 8'hEE;
    @(negedge clk);
    chk("wrap_last_ready", a_ready, 1);
    wait_drain(50);
    chk("wrap_zero", drained_cnt, 8'h00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
